// File: rtl/mux_skid_pkg.sv
// rtl/mux_skid_pkg.sv - shared types and helpers for the mux_skid_n skid-buffered selector
package mux_skid_pkg;

    localparam int MAX_N    = 16;
    localparam int MAX_SELW = $clog2(MAX_N);

    // Encoding is {main_valid, skid_valid}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        FULL  = 2'b11
    } state_e;

    function automatic logic sel_in_range(input logic [MAX_SELW-1:0] sel, input int n);
        return int'(sel) < n;
    endfunction

endpackage

// File: rtl/mux2_cell.sv
// rtl/mux2_cell.sv - WIDTH-bit 2:1 mux cell; DELAY is kept for gate-level annotation, RTL is zero-delay
module mux2_cell #(
    parameter int WIDTH = 1,
    parameter int DELAY = 50
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sel_i,
    output logic [WIDTH-1:0] y_o
);

    if (DELAY < 0) begin : g_bad_delay
        $error("mux2_cell: DELAY must be non-negative");
    end

    assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux_n_w.sv
// rtl/mux_n_w.sv - combinational N:1 WIDTH-bit selector built as a heap-indexed tree of mux2_cell
module mux_n_w #(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    parameter  int DELAY = 50,
    localparam int SELW  = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in_data_i,
    input  logic [SELW-1:0]    sel_i,
    output logic [WIDTH-1:0]   data_o
);

    localparam int LEAVES = 1 << SELW;

    // node[0] is the root; leaves sit at LEAVES-1 .. 2*LEAVES-2.
    logic [WIDTH-1:0] node [2*LEAVES-1];

    for (genvar k = 0; k < LEAVES; k++) begin : g_leaf
        if (k < N) begin : g_src
            assign node[LEAVES-1+k] = in_data_i[k*WIDTH +: WIDTH];
        end else begin : g_tie
            assign node[LEAVES-1+k] = '0;
        end
    end

    // The root steers on the select MSB, each deeper level on the next bit down.
    for (genvar i = 0; i < LEAVES-1; i++) begin : g_node
        localparam int D = $clog2(i + 2) - 1;
        mux2_cell #(
            .WIDTH (WIDTH),
            .DELAY (DELAY)
        ) u_cell (
            .a_i   (node[2*i+1]),
            .b_i   (node[2*i+2]),
            .sel_i (sel_i[SELW-1-D]),
            .y_o   (node[i])
        );
    end

    assign data_o = node[0];

endmodule

// File: rtl/mux_skid_n.sv
// rtl/mux_skid_n.sv - N:1 source select registered into a 2-entry skid buffer with valid/ready and flush
module mux_skid_n
    import mux_skid_pkg::*;
#(
    parameter  int WIDTH = 64,
    parameter  int N     = 4,
    parameter  int DELAY = 50,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SELW-1:0]    in_sel,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               sel_err
);

    if (N < 2 || N > MAX_N) begin : g_bad_n
        $error("mux_skid_n: N must be in 2..16");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             sel_err_q, sel_err_d;

    logic [WIDTH-1:0]    tree_y;
    logic [WIDTH-1:0]    mux_val;
    logic [MAX_SELW-1:0] sel_ext;
    logic                sel_ok;
    logic                accept;
    logic                pop;

    mux_n_w #(
        .WIDTH (WIDTH),
        .N     (N),
        .DELAY (DELAY)
    ) u_mux (
        .in_data_i (in_data),
        .sel_i     (in_sel),
        .data_o    (tree_y)
    );

    assign sel_ext = MAX_SELW'(in_sel);
    assign sel_ok  = sel_in_range(sel_ext, N);
    // Zero-tied leaves already give 0 out of range; the gate keeps that explicit.
    assign mux_val = sel_ok ? tree_y : '0;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign sel_err   = sel_err_q;

    assign accept = in_valid & in_ready;
    assign pop    = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        main_d    = main_q;
        skid_d    = skid_q;
        sel_err_d = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            sel_err_d = accept & ~sel_ok;
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_d  = mux_val;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_d = mux_val;
                    end else if (accept) begin
                        skid_d  = mux_val;
                        state_d = FULL;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        main_d  = skid_q;
                        state_d = ONE;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            main_q    <= '0;
            skid_q    <= '0;
            sel_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            main_q    <= main_d;
            skid_q    <= skid_d;
            sel_err_q <= sel_err_d;
        end
    end

endmodule

// File: tb/tb_mux_skid_n.sv
// tb/tb_mux_skid_n.sv - randomized and directed bench for mux_skid_n at N=4 and N=3 against a queue model
module tb_mux_skid_n;

    localparam int W = 64;
    localparam logic [W-1:0] VAL_A = 64'hAAAA_0000_1111_000A;
    localparam logic [W-1:0] VAL_B = 64'hBBBB_0000_2222_000B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, in_valid, out_ready, flush;
    logic [1:0]   sel;
    logic [W-1:0] src [4];

    logic [4*W-1:0] in_data4;
    logic [3*W-1:0] in_data3;
    assign in_data4 = {src[3], src[2], src[1], src[0]};
    assign in_data3 = {src[2], src[1], src[0]};

    logic         rdy4, ov4, se4, rdy3, ov3, se3;
    logic [W-1:0] od4, od3;

    mux_skid_n #(.WIDTH(W), .N(4), .DELAY(50)) dut4 (
        .clk(clk), .reset(reset), .in_data(in_data4), .in_sel(sel), .in_valid(in_valid),
        .in_ready(rdy4), .flush(flush), .out_data(od4), .out_valid(ov4),
        .out_ready(out_ready), .sel_err(se4)
    );

    mux_skid_n #(.WIDTH(W), .N(3), .DELAY(50)) dut3 (
        .clk(clk), .reset(reset), .in_data(in_data3), .in_sel(sel), .in_valid(in_valid),
        .in_ready(rdy3), .flush(flush), .out_data(od3), .out_valid(ov3),
        .out_ready(out_ready), .sel_err(se3)
    );

    // Reference: each buffer is a FIFO of at most two entries.
    logic [W-1:0] q4 [$];
    logic [W-1:0] q3 [$];
    logic         exp_se4 = 1'b0;
    logic         exp_se3 = 1'b0;

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic check_outputs();
        check("rdy4", rdy4, q4.size() < 2);
        check("ov4", ov4, q4.size() > 0);
        if (q4.size() > 0) check("od4", od4, q4[0]);
        check("se4", se4, exp_se4);
        check("rdy3", rdy3, q3.size() < 2);
        check("ov3", ov3, q3.size() > 0);
        if (q3.size() > 0) check("od3", od3, q3[0]);
        check("se3", se3, exp_se3);
    endtask

    task automatic step();
        bit acc4, acc3;
        logic [W-1:0] v4, v3;
        @(posedge clk);
        acc4 = in_valid && (q4.size() < 2);
        acc3 = in_valid && (q3.size() < 2);
        v4 = src[sel];
        v3 = (sel < 3) ? src[sel] : '0;
        if (reset || flush) begin
            q4.delete();
            q3.delete();
            exp_se4 = 1'b0;
            exp_se3 = 1'b0;
        end else begin
            exp_se4 = 1'b0;
            exp_se3 = acc3 && (sel == 2'd3);
            if (q4.size() > 0 && out_ready) void'(q4.pop_front());
            if (q3.size() > 0 && out_ready) void'(q3.pop_front());
            if (acc4) q4.push_back(v4);
            if (acc3) q3.push_back(v3);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic r, input logic f);
        in_valid  = v;
        sel       = s;
        out_ready = r;
        flush     = f;
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b0, 2'd0, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) src[k] = {$urandom, $urandom};
        step();
        step();
        reset = 1'b0;
        check("rst_od", od4, '0);
        check("rst_rdy", rdy4, 1'b1);
        check("rst_ov", ov4, 1'b0);
        check("rst_se", se3, 1'b0);

        // Single transfer
        src[2] = 64'hDEAD_BEEF_0000_0002;
        drive(1'b1, 2'd2, 1'b1, 1'b0);
        step();
        check("single_ov", ov4, 1'b1);
        check("single_od", od4, 64'hDEAD_BEEF_0000_0002);
        check("single_rdy", rdy4, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("single_ov_after", ov4, 1'b0);
        check("single_rdy_after", rdy4, 1'b1);

        // Backpressure: A then B with out_ready low
        src[0] = VAL_A;
        src[1] = VAL_B;
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        step();
        check("bp_full_rdy", rdy4, 1'b0);
        check("bp_head_a", od4, VAL_A);
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        step();
        step();
        check("bp_hold_a", od4, VAL_A);
        check("bp_hold_ov", ov4, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("bp_head_b", od4, VAL_B);
        check("bp_rdy_back", rdy4, 1'b1);
        step();
        check("bp_drained", ov4, 1'b0);

        // Streaming at full throughput
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) src[k] = {$urandom, $urandom};
            drive(1'b1, 2'(i % 4), 1'b1, 1'b0);
            step();
            check("stream_not_full", rdy4, 1'b1);
            check("stream_head", od4, src[i % 4]);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();

        // Out-of-range select on the N=3 instance
        src[0] = {$urandom, $urandom};
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        step();
        check("oor_od3", od3, '0);
        check("oor_se3", se3, 1'b1);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        check("oor_se3_clear", se3, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        step();

        // Flush beats accept and pop
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        step();
        step();
        check("fl_full", rdy4, 1'b0);
        drive(1'b1, 2'd2, 1'b1, 1'b1);
        step();
        check("fl_ov", ov4, 1'b0);
        check("fl_rdy", rdy4, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();
        check("fl_ov_after", ov4, 1'b0);

        // Reset while FULL, with an out-of-range entry pending on N=3
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        step();
        step();
        reset = 1'b1;
        drive(1'b1, 2'd3, 1'b1, 1'b0);
        step();
        reset = 1'b0;
        check("mr_ov", ov4, 1'b0);
        check("mr_rdy", rdy4, 1'b1);
        check("mr_se3", se3, 1'b0);
        src[0] = {$urandom, $urandom};
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        step();
        check("mr_lat1_ov", ov4, 1'b1);
        check("mr_lat1_od", od4, src[0]);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        step();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 4; k++) src[k] = {$urandom, $urandom};
            reset = ($urandom_range(63) == 0);
            drive(1'($urandom_range(1)), 2'($urandom_range(3)),
                  1'($urandom_range(2) != 0), 1'($urandom_range(15) == 0));
            step();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
